// File: rtl/rs232_pkg.sv
// rs232_pkg: shared types and constants for the RS-232 byte transceiver.
//   DATA_BITS  - data bits per character (8N1 framing)
//   IDLE_LEVEL - line level while idle and during the stop bit
//   rx_state_t - receive FSM states
//   tx_state_t - transmit FSM states
package rs232_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOADING,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/rs232_bit_timer.sv
// rs232_bit_timer: bit-period down-counter with terminal-count tick.
//   clk       in  system clock
//   rst       in  synchronous active-high reset (counter to 0)
//   load      in  preload a full bit period
//   load_half in  preload half a bit period (start-bit centring)
//   run       in  count down; reload a full period on terminal count
//   tick      out high for the one cycle the counter sits at 0 while running
// The tick occurs CLKS_PER_BIT cycles after a full preload (CLKS_PER_BIT/2
// after a half preload), and every CLKS_PER_BIT cycles thereafter.
module rs232_bit_timer
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_half,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= FULL;
    end else if (load_half) begin
      cnt <= HALF;
    end else if (run) begin
      cnt <= (cnt == '0) ? FULL : cnt - CW'(1);
    end
  end

  assign tick = run && (cnt == '0);

endmodule

// File: rtl/rs232_transceiver.sv
// rs232_transceiver: 8N1 RS-232 byte transceiver, LSB first, full duplex.
//   CLK   in   system clock
//   INIT  in   synchronous active-high reset
//   RX    in   asynchronous serial input, idle high
//   STORE out  one-cycle pulse, DOUT holds a new byte
//   DOUT  out  last received byte
//   DRL   in   transmit request level
//   DIN   in   byte to send, sampled the cycle after LOAD
//   LOAD  out  one-cycle pulse, transmitter commits to one byte
//   TX    out  serial output, idle high
// Optional feature macro RS232_FRAMING_CHECK_EN: drop bytes whose stop-bit
// sample is low (no STORE, DOUT unchanged).
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a high-to-low edge on the synchronized line
//   RX_START | half a bit in; confirm the start bit is still low
//   RX_DATA  | sampling 8 data bits mid-bit, LSB first
//   RX_STOP  | sampling the stop bit; deliver byte
// TX FSM
//   state      | meaning
//   TX_IDLE    | line high, waiting for DRL
//   TX_LOADING | LOAD cycle; latch DIN, drive start bit at the next edge
//   TX_START   | start bit
//   TX_DATA    | 8 data bits LSB first
//   TX_STOP    | stop bit; chain straight into LOAD if DRL is still high
module rs232_transceiver
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 CLK,
  input  logic                 INIT,
  input  logic                 RX,
  output logic                 STORE,
  output logic [DATA_BITS-1:0] DOUT,
  input  logic                 DRL,
  input  logic [DATA_BITS-1:0] DIN,
  output logic                 LOAD,
  output logic                 TX
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  // Synchronizer and previous-sample flop reset to the non-idle level so a
  // line held low through reset release never looks like a falling edge.
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_prev;
  logic                   rx_s;
  logic                   rx_fall;

  assign rx_s    = rx_sync[SYNC_STAGES-1];
  assign rx_fall = (rx_prev == IDLE_LEVEL) && (rx_s != IDLE_LEVEL);

  always_ff @(posedge CLK) begin
    if (INIT) begin
      rx_sync <= {SYNC_STAGES{~IDLE_LEVEL}};
      rx_prev <= ~IDLE_LEVEL;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], RX};
      rx_prev <= rx_s;
    end
  end

  rx_state_t            rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic [BW-1:0]        rx_bit;
  logic                 rx_tick;
  logic                 rx_arm;
  logic                 rx_run;

  assign rx_arm = (rx_state == RX_IDLE) && rx_fall;
  assign rx_run = (rx_state != RX_IDLE);

  rs232_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk       (CLK),
    .rst       (INIT),
    .load      (1'b0),
    .load_half (rx_arm),
    .run       (rx_run),
    .tick      (rx_tick)
  );

  always_ff @(posedge CLK) begin
    if (INIT) begin
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_bit   <= '0;
      STORE    <= 1'b0;
      DOUT     <= '0;
    end else begin
      STORE <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_tick) begin
            if (rx_s == IDLE_LEVEL) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
            else rx_bit <= rx_bit + BW'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_state <= RX_IDLE;
`ifdef RS232_FRAMING_CHECK_EN
            if (rx_s == IDLE_LEVEL) begin
              STORE <= 1'b1;
              DOUT  <= rx_shift;
            end
`else
            STORE <= 1'b1;
            DOUT  <= rx_shift;
`endif
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [BW-1:0]        tx_bit;
  logic                 tx_tick;
  logic                 tx_load;
  logic                 tx_run;

  assign tx_load = (tx_state == TX_LOADING);
  assign tx_run  = (tx_state == TX_START) || (tx_state == TX_DATA) ||
                   (tx_state == TX_STOP);

  rs232_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk       (CLK),
    .rst       (INIT),
    .load      (tx_load),
    .load_half (1'b0),
    .run       (tx_run),
    .tick      (tx_tick)
  );

  always_ff @(posedge CLK) begin
    if (INIT) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      TX       <= IDLE_LEVEL;
      LOAD     <= 1'b0;
    end else begin
      LOAD <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          TX <= IDLE_LEVEL;
          if (DRL) begin
            LOAD     <= 1'b1;
            tx_state <= TX_LOADING;
          end
        end
        TX_LOADING: begin
          tx_shift <= DIN;
          TX       <= ~IDLE_LEVEL;
          tx_state <= TX_START;
        end
        TX_START: begin
          if (tx_tick) begin
            TX       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_bit == LAST_BIT) begin
              TX       <= IDLE_LEVEL;
              tx_state <= TX_STOP;
            end else begin
              TX       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              tx_bit   <= tx_bit + BW'(1);
            end
          end
        end
        TX_STOP: begin
          // The LOAD cycle that chains the next byte doubles as the idle cycle.
          if (tx_tick) begin
            if (DRL) begin
              LOAD     <= 1'b1;
              tx_state <= TX_LOADING;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_transceiver.sv
// tb_rs232_transceiver: directed self-checking bench for rs232_transceiver.
// A cycle-level model tracks the expected TX/LOAD waveform from DRL/DIN and
// the expected STORE/DOUT from the bytes put on the RX line; a compare
// process checks every cycle, and literal expectations pin the model.
module tb_rs232_transceiver;

  localparam int C    = 16;
  localparam int SYNC = 2;
  // RX line change after edge n -> STORE high after edge n + LAT
  localparam int LAT  = SYNC + 1 + C / 2 + 9 * C;

  logic       CLK = 1'b0;
  logic       INIT = 1'b1;
  logic       RX;
  logic       DRL = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       STORE;
  logic       LOAD;
  logic       TX;
  logic [7:0] DOUT;

  logic rx_drive = 1'b1;
  logic loopback = 1'b0;
  assign RX = loopback ? TX : rx_drive;

  rs232_transceiver #(.CLKS_PER_BIT(C), .SYNC_STAGES(SYNC)) dut (
    .CLK   (CLK),
    .INIT  (INIT),
    .RX    (RX),
    .STORE (STORE),
    .DOUT  (DOUT),
    .DRL   (DRL),
    .DIN   (DIN),
    .LOAD  (LOAD),
    .TX    (TX)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit         m_valid = 0;
  bit         m_busy  = 0;
  int         m_age   = 0;
  logic [7:0] m_byte  = 8'h00;
  logic       exp_tx   = 1'b1;
  logic       exp_load = 1'b0;
  logic [7:0] exp_dout = 8'h00;
  int         exp_store_cyc[$];
  logic [7:0] exp_store_val[$];
  int         store_cyc_log[$];
  logic [7:0] store_val_log[$];
  int         load_cyc_log[$];
  logic       tx_hist[0:8191];

  // Line level of a frame "age" cycles after the edge that raised LOAD:
  // 1..C start, then 8 data bits of C cycles, then the stop bit.
  function automatic logic tx_level(input bit busy, input int age, input logic [7:0] b);
    int pos;
    if (!busy || age == 0) return 1'b1;
    pos = (age - 1) / C;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    cyc++;
    if (INIT) begin
      m_valid  = 1;
      m_busy   = 0;
      m_age    = 0;
      exp_dout = 8'h00;
      exp_store_cyc.delete();
      exp_store_val.delete();
    end else if (!m_busy) begin
      if (DRL) begin
        m_busy = 1;
        m_age  = 0;
      end
    end else begin
      m_age++;
      if (m_age == 1) begin
        m_byte = DIN;
        if (loopback) begin
          exp_store_cyc.push_back(cyc + LAT);
          exp_store_val.push_back(DIN);
        end
      end else if (m_age == 10 * C + 1) begin
        if (DRL) m_age = 0;
        else m_busy = 0;
      end
    end
    exp_load = m_busy && (m_age == 0);
    exp_tx   = tx_level(m_busy, m_age, m_byte);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (m_valid) begin
      if (cyc < 8192) tx_hist[cyc] = TX;
      if (LOAD === 1'b1) load_cyc_log.push_back(cyc);
      chk1("tx", TX, exp_tx);
      chk1("load", LOAD, exp_load);
      if (STORE === 1'b1) begin
        store_cyc_log.push_back(cyc);
        store_val_log.push_back(DOUT);
        checks++;
        if (exp_store_cyc.size() > 0 && cyc >= exp_store_cyc[0] - 1 &&
            cyc <= exp_store_cyc[0] + 1) begin
          if (DOUT !== exp_store_val[0]) begin
            errors++;
            $display("FAIL store_value: got %h expected %h (cycle %0d)", DOUT, exp_store_val[0], cyc);
          end
          exp_dout = exp_store_val[0];
          void'(exp_store_cyc.pop_front());
          void'(exp_store_val.pop_front());
        end else begin
          errors++;
          $display("FAIL store_unexpected: got STORE=1 expected 0 (cycle %0d)", cyc);
        end
      end else if (exp_store_cyc.size() > 0 && cyc > exp_store_cyc[0] + 1) begin
        checks++;
        errors++;
        $display("FAIL store_missing: got no STORE expected one near cycle %0d", exp_store_cyc[0]);
        void'(exp_store_cyc.pop_front());
        void'(exp_store_val.pop_front());
      end
      chk8("dout", DOUT, exp_dout);
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit expect_store,
                         output int fall_cyc);
    @(negedge CLK);
    rx_drive = 1'b0;
    fall_cyc = cyc;
    if (expect_store) begin
      exp_store_cyc.push_back(cyc + LAT);
      exp_store_val.push_back(b);
    end
    repeat (C) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      repeat (C) @(negedge CLK);
    end
    rx_drive = stop_bit;
    repeat (C) @(negedge CLK);
    rx_drive = 1'b1;
  endtask

  task automatic wait_load(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge CLK);
      if (LOAD === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_timeout: got no LOAD expected one within %0d cycles", limit);
    end
  endtask

  // Decode a TX frame at mid-bit from the recorded line history.
  task automatic check_tx_frame(input string name, input int l_cyc, input logic [7:0] b);
    logic [7:0] got;
    logic       st;
    logic       sp;
    int         base;
    base = l_cyc + 1 + C / 2;
    st = tx_hist[base];
    for (int i = 0; i < 8; i++) got[i] = tx_hist[base + (i + 1) * C];
    sp = tx_hist[base + 9 * C];
    checks++;
    if (st !== 1'b0 || sp !== 1'b1 || got !== b) begin
      errors++;
      $display("FAIL %s: got start=%b data=%h stop=%b expected start=0 data=%h stop=1",
               name, st, got, sp, b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         f;
    int         n0;
    int         l0;
    int         lat;
    logic [7:0] tx_bytes[3];
    tx_bytes[0] = 8'h06;
    tx_bytes[1] = 8'h14;
    tx_bytes[2] = 8'h07;

    INIT = 1'b1;
    repeat (3) @(negedge CLK);
    chk1("rst_tx", TX, 1'b1);
    chk1("rst_load", LOAD, 1'b0);
    chk1("rst_store", STORE, 1'b0);
    chk8("rst_dout", DOUT, 8'h00);
    INIT = 1'b0;
    repeat (5) @(negedge CLK);

    // single received byte
    n0 = store_val_log.size();
    send_rx(8'hA5, 1'b1, 1'b1, f);
    repeat (10) @(negedge CLK);
    chk_int("a5_count", store_val_log.size() - n0, 1);
    if (store_val_log.size() > n0) begin
      chk8("a5_value", store_val_log[n0], 8'hA5);
      lat = store_cyc_log[n0] - f;
      checks++;
      if (lat < 153 || lat > 156) begin
        errors++;
        $display("FAIL a5_latency: got %0d expected 153..156", lat);
      end
    end

    // back-to-back transmit, DRL dropped in the third LOAD cycle
    l0 = load_cyc_log.size();
    DRL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_load(200);
      DIN = tx_bytes[k];
      if (k == 2) DRL = 1'b0;
    end
    repeat (10 * C + 30) @(negedge CLK);
    chk_int("tx_load_count", load_cyc_log.size() - l0, 3);
    if (load_cyc_log.size() >= l0 + 3) begin
      chk_int("tx_pitch_1", load_cyc_log[l0+1] - load_cyc_log[l0], 161);
      chk_int("tx_pitch_2", load_cyc_log[l0+2] - load_cyc_log[l0+1], 161);
      check_tx_frame("tx_frame_0", load_cyc_log[l0], 8'h06);
      check_tx_frame("tx_frame_1", load_cyc_log[l0+1], 8'h14);
      check_tx_frame("tx_frame_2", load_cyc_log[l0+2], 8'h07);
    end
    chk1("tx_idle_after", TX, 1'b1);

    // short low glitch, then a real byte
    n0 = store_val_log.size();
    rx_drive = 1'b0;
    repeat (4) @(negedge CLK);
    rx_drive = 1'b1;
    repeat (3 * C) @(negedge CLK);
    chk_int("glitch_no_store", store_val_log.size() - n0, 0);
    send_rx(8'h3C, 1'b1, 1'b1, f);
    repeat (10) @(negedge CLK);
    chk_int("after_glitch_count", store_val_log.size() - n0, 1);
    chk8("after_glitch_dout", DOUT, 8'h3C);

    // stop bit sampled low
    n0 = store_val_log.size();
`ifdef RS232_FRAMING_CHECK_EN
    send_rx(8'hFF, 1'b0, 1'b0, f);
    repeat (2 * C) @(negedge CLK);
    chk_int("framing_count", store_val_log.size() - n0, 0);
    chk8("framing_dout", DOUT, 8'h3C);
`else
    send_rx(8'hFF, 1'b0, 1'b1, f);
    repeat (2 * C) @(negedge CLK);
    chk_int("framing_count", store_val_log.size() - n0, 1);
    chk8("framing_dout", DOUT, 8'hFF);
`endif

    // INIT during bit 4 of both a TX and an RX byte
    n0 = store_val_log.size();
    fork
      send_rx(8'h96, 1'b1, 1'b0, f);
      begin
        DRL = 1'b1;
        wait_load(20);
        DIN = 8'hC3;
        DRL = 1'b0;
        repeat (5 * C + 6) @(negedge CLK);
        INIT = 1'b1;
        @(negedge CLK);
        chk1("init_mid_tx", TX, 1'b1);
        chk1("init_mid_load", LOAD, 1'b0);
        chk1("init_mid_store", STORE, 1'b0);
        chk8("init_mid_dout", DOUT, 8'h00);
      end
    join
    repeat (3) @(negedge CLK);
    INIT = 1'b0;
    repeat (2 * C) @(negedge CLK);
    chk_int("init_mid_no_store", store_val_log.size() - n0, 0);

    // loopback, two bytes back to back
    n0 = store_val_log.size();
    loopback = 1'b1;
    DRL = 1'b1;
    wait_load(20);
    DIN = 8'h55;
    wait_load(200);
    DIN = 8'hAA;
    DRL = 1'b0;
    repeat (10 * C + LAT + 20) @(negedge CLK);
    chk_int("loop_count", store_val_log.size() - n0, 2);
    if (store_val_log.size() >= n0 + 2) begin
      chk8("loop_first", store_val_log[n0], 8'h55);
      chk8("loop_second", store_val_log[n0+1], 8'hAA);
    end
    loopback = 1'b0;
    repeat (5) @(negedge CLK);
    chk_int("pending_stores", exp_store_cyc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
